// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and reset values.
// Combinational only: no latency and no flow control.
// Imported by branch_predictor and sat_counter2.
package branch_predictor_pkg;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_e;

   localparam logic [1:0]  BHT_RESET_VAL = WEAK_NT;
   localparam logic [31:0] STAT_MAX      = 32'hFFFF_FFFF;

   function automatic logic ctr_says_taken(input logic [1:0] ctr);
      return ctr[1];
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next state of a 2-bit saturating direction counter.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of (cur, taken).
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       taken,
   output logic [1:0] nxt
);

   always_comb begin
      nxt = cur;
      if (taken) begin
         if (cur != STRONG_T) nxt = cur + 2'd1;
      end else begin
         if (cur != STRONG_NT) nxt = cur - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage predictor: PC-indexed 2-bit BHT plus direct-mapped tagged BTB, trained from EX.
// Latency: lookup is combinational (zero cycles); training lands on the next rising edge.
// Backpressure: none; ex_stall freezes training and statistics. Optional gshare via BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int BHT_INDEX_BITS = 6,
   parameter int BTB_INDEX_BITS = 4,
   parameter int XLEN           = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [XLEN-1:0]           if_pc,
   output logic                      pred_taken,
   output logic [XLEN-1:0]           pred_target,
   output logic [BHT_INDEX_BITS-1:0] pred_index,
   input  logic                      ex_branch,
   input  logic                      ex_stall,
   input  logic [XLEN-1:0]           ex_pc,
   input  logic [BHT_INDEX_BITS-1:0] ex_pred_index,
   input  logic                      ex_taken,
   input  logic [XLEN-1:0]           ex_target,
   input  logic                      ex_miss,
   output logic [31:0]               stat_branches,
   output logic [31:0]               stat_misses
);

   localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;
   localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
   localparam int TAG_W       = XLEN - BTB_INDEX_BITS - 2;

   logic [1:0]       bht     [BHT_ENTRIES];
   logic             btb_vld [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag [BTB_ENTRIES];
   logic [XLEN-1:0]  btb_tgt [BTB_ENTRIES];

   logic [BHT_INDEX_BITS-1:0] pc_bht_idx;
   logic [BTB_INDEX_BITS-1:0] if_btb_idx;
   logic [BTB_INDEX_BITS-1:0] ex_btb_idx;
   logic [TAG_W-1:0]          if_tag;
   logic [TAG_W-1:0]          ex_tag;
   logic                      btb_hit;
   logic                      train;
   logic [1:0]                ctr_nxt;
   logic                      unused_pc_bits;

   assign pc_bht_idx     = if_pc[BHT_INDEX_BITS+1:2];
   assign if_btb_idx     = if_pc[BTB_INDEX_BITS+1:2];
   assign if_tag         = if_pc[XLEN-1:BTB_INDEX_BITS+2];
   assign ex_btb_idx     = ex_pc[BTB_INDEX_BITS+1:2];
   assign ex_tag         = ex_pc[XLEN-1:BTB_INDEX_BITS+2];
   assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

   assign train = ex_branch && !ex_stall;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [BHT_INDEX_BITS-1:0] ghr;

   assign pred_index = pc_bht_idx ^ ghr;

   // History only advances on resolved, unstalled branches, so it never needs repair.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ghr <= '0;
      end else if (train) begin
         ghr <= {ghr[BHT_INDEX_BITS-2:0], ex_taken};
      end
   end
`else
   assign pred_index = pc_bht_idx;
`endif

   // A counter saying taken is ignored unless the BTB can also supply a target.
   assign btb_hit     = btb_vld[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
   assign pred_taken  = btb_hit && ctr_says_taken(bht[pred_index]);
   assign pred_target = pred_taken ? btb_tgt[if_btb_idx] : if_pc + XLEN'(4);

   sat_counter2 u_sat_counter2 (
      .cur   (bht[ex_pred_index]),
      .taken (ex_taken),
      .nxt   (ctr_nxt)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_RESET_VAL;
         for (int j = 0; j < BTB_ENTRIES; j++) btb_vld[j] <= 1'b0;
         stat_branches <= '0;
         stat_misses   <= '0;
      end else if (train) begin
         bht[ex_pred_index] <= ctr_nxt;
         if (ex_taken) btb_vld[ex_btb_idx] <= 1'b1;
         if (stat_branches != STAT_MAX) stat_branches <= stat_branches + 32'd1;
         if (ex_miss && (stat_misses != STAT_MAX)) stat_misses <= stat_misses + 32'd1;
      end
   end

   // Tag and target payload are qualified by btb_vld, so they carry no reset.
   always_ff @(posedge clk) begin
      if (reset_n && train && ex_taken) begin
         btb_tag[ex_btb_idx] <= ex_tag;
         btb_tgt[ex_btb_idx] <= ex_target;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;

   localparam int BHT_N = 64;
   localparam int BTB_N = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [5:0]  pred_index;
   logic        ex_branch;
   logic        ex_stall;
   logic [31:0] ex_pc;
   logic [5:0]  ex_pred_index;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_miss;
   logic [31:0] stat_branches;
   logic [31:0] stat_misses;

   branch_predictor #(.BHT_INDEX_BITS(6), .BTB_INDEX_BITS(4), .XLEN(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .if_pc         (if_pc),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .pred_index    (pred_index),
      .ex_branch     (ex_branch),
      .ex_stall      (ex_stall),
      .ex_pc         (ex_pc),
      .ex_pred_index (ex_pred_index),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .ex_miss       (ex_miss),
      .stat_branches (stat_branches),
      .stat_misses   (stat_misses)
   );

   always #5 clk = ~clk;

   // Reference model: counters as integers 0..3, BTB as plain arrays keyed by (pc/4) mod 16.
   int          m_ctr   [BHT_N];
   bit          m_valid [BTB_N];
   int unsigned m_tag   [BTB_N];
   int unsigned m_tgt   [BTB_N];
   longint      m_branches;
   longint      m_misses;
   int          m_ghr;
   bit          model_known = 1'b0;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_lookup_index(input int unsigned pc);
      int idx;
      idx = int'((pc / 4) % BHT_N);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      idx = idx ^ m_ghr;
`endif
      return idx;
   endfunction

   // Drive one cycle's inputs away from the edge and compare outputs with the model's pre-edge state.
   task automatic drive(input logic rst_n, input logic [31:0] pc, input logic br, input logic st,
                        input logic [31:0] epc, input logic [5:0] eidx, input logic tk,
                        input logic [31:0] etgt, input logic ms);
      int          idx;
      int          bi;
      bit          hit;
      bit          exp_taken;
      int unsigned exp_target;
      @(negedge clk);
      reset_n       = rst_n;
      if_pc         = pc;
      ex_branch     = br;
      ex_stall      = st;
      ex_pc         = epc;
      ex_pred_index = eidx;
      ex_taken      = tk;
      ex_target     = etgt;
      ex_miss       = ms;
      #1;
      if (model_known) begin
         idx        = m_lookup_index(pc);
         bi         = int'((pc / 4) % BTB_N);
         hit        = m_valid[bi] && (m_tag[bi] == pc / 64);
         exp_taken  = hit && (m_ctr[idx] >= 2);
         exp_target = exp_taken ? m_tgt[bi] : pc + 32'd4;
         check("pred_index",    64'(pred_index),    64'(idx));
         check("pred_taken",    64'(pred_taken),    64'(exp_taken));
         check("pred_target",   64'(pred_target),   64'(exp_target));
         check("stat_branches", 64'(stat_branches), 64'(m_branches));
         check("stat_misses",   64'(stat_misses),   64'(m_misses));
      end
   endtask

   task automatic advance();
      int bi;
      @(posedge clk);
      if (!reset_n) begin
         for (int i = 0; i < BHT_N; i++) m_ctr[i] = 1;
         for (int i = 0; i < BTB_N; i++) m_valid[i] = 1'b0;
         m_branches  = 0;
         m_misses    = 0;
         m_ghr       = 0;
         model_known = 1'b1;
      end else if (ex_branch && !ex_stall) begin
         if (ex_taken) m_ctr[ex_pred_index] = (m_ctr[ex_pred_index] == 3) ? 3 : m_ctr[ex_pred_index] + 1;
         else          m_ctr[ex_pred_index] = (m_ctr[ex_pred_index] == 0) ? 0 : m_ctr[ex_pred_index] - 1;
         if (ex_taken) begin
            bi          = int'((ex_pc / 4) % BTB_N);
            m_valid[bi] = 1'b1;
            m_tag[bi]   = ex_pc / 64;
            m_tgt[bi]   = ex_target;
         end
         if (m_branches < 64'hFFFF_FFFF) m_branches++;
         if (ex_miss && m_misses < 64'hFFFF_FFFF) m_misses++;
         m_ghr = ((m_ghr * 2) + int'(ex_taken)) % BHT_N;
      end
   endtask

   task automatic idle(input logic [31:0] pc);
      drive(1'b1, pc, 1'b0, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic train(input logic [31:0] epc, input logic [5:0] eidx, input logic tk, input logic [31:0] etgt);
      drive(1'b1, epc, 1'b1, 1'b0, epc, eidx, tk, etgt, 1'b0);
      advance();
   endtask

   logic [31:0] pool [8];

   initial begin
      pool[0] = 32'h0000_0100; pool[1] = 32'h0000_0140; pool[2] = 32'h0000_0104; pool[3] = 32'h0000_0180;
      pool[4] = 32'h0000_01C0; pool[5] = 32'h0000_0200; pool[6] = 32'hFFFF_FFFC; pool[7] = 32'h0000_1100;

      // Reset held for two edges with a training event riding on top of it.
      drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 6'h0, 1'b1, 32'h80, 1'b1);
      advance();
      drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 6'h0, 1'b1, 32'h80, 1'b1);
      advance();

      // First taken training at 0x100, carrying a miss.
      drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 6'h0, 1'b1, 32'h80, 1'b1);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
      check("rst_pred_taken",  64'(pred_taken),    64'h0);
      check("rst_pred_target", 64'(pred_target),   64'h104);
      check("rst_branches",    64'(stat_branches), 64'h0);
`endif
      advance();

      idle(32'h100);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
      check("trained_taken",  64'(pred_taken),    64'h1);
      check("trained_target", 64'(pred_target),   64'h80);
      check("trained_count",  64'(stat_branches), 64'h1);
`endif
      advance();

      repeat (2) train(32'h100, 6'h0, 1'b1, 32'h80);
      repeat (3) train(32'h100, 6'h0, 1'b0, 32'h0);
      idle(32'h100);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
      check("sat_down_taken",  64'(pred_taken),  64'h0);
      check("sat_down_target", 64'(pred_target), 64'h104);
`endif
      advance();

      // 0x140 shares BTB slot 0 with 0x100 under a different tag.
      repeat (2) train(32'h100, 6'h0, 1'b1, 32'h80);
      train(32'h140, 6'h10, 1'b1, 32'h300);
      idle(32'h100);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
      check("alias_evicted", 64'(pred_taken), 64'h0);
`endif
      advance();
      idle(32'h140);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
      check("alias_own_target", 64'(pred_target), 64'h300);
`endif
      advance();

      drive(1'b1, 32'h140, 1'b1, 1'b1, 32'h140, 6'h10, 1'b0, 32'h0, 1'b1);
      advance();
      idle(32'h140);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
      check("stall_keeps_taken", 64'(pred_taken), 64'h1);
`endif
      advance();

      drive(1'b0, 32'h140, 1'b1, 1'b0, 32'h140, 6'h10, 1'b1, 32'h300, 1'b1);
      advance();
      idle(32'h140);
      check("reset_clears_btb",   64'(pred_taken),    64'h0);
      check("reset_clears_stats", 64'(stat_branches), 64'h0);
      advance();

      idle(32'hFFFF_FFFC);
      check("wrap_target", 64'(pred_target), 64'h0);
      advance();

      // Randomized traffic concentrated on a few aliasing PCs.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] pc;
         logic [31:0] epc;
         logic [5:0]  eidx;
         pc   = pool[$urandom_range(7)];
         epc  = pool[$urandom_range(7)];
         eidx = ($urandom_range(3) == 0) ? 6'($urandom) : 6'(m_lookup_index(epc));
         drive(($urandom_range(60) != 0), pc, ($urandom_range(3) != 0), ($urandom_range(4) == 0),
               epc, eidx, 1'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom));
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Upstream partner of the branch resolution logic in EX.
- Sits in IF. Produces, for every fetched PC:
  - a taken/not-taken estimate (becomes `branch_estimation` downstream);
  - a predicted target;
  - the table index used for the prediction.
- Trains non-speculatively from the EX-stage resolution (`branch`, `branch_taken`, `branch_target_actual`).
- Structure: PC-indexed table of 2-bit saturating counters (BHT) plus a direct-mapped tagged target buffer (BTB). Also keeps branch/miss statistics counters.

Parameters:
- BHT_INDEX_BITS, 6, log2 of BHT entries (64 counters).
- BTB_INDEX_BITS, 4, log2 of BTB entries (16 entries).
- XLEN, 32, address width.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- if_pc  in  XLEN  PC being fetched
- pred_taken  out  1  predicted direction (to IF/ID pipe, later `branch_estimation`)
- pred_target  out  XLEN  predicted next PC
- pred_index  out  BHT_INDEX_BITS  BHT index used; carried down the pipe
- ex_branch  in  1  EX holds a resolved conditional branch this cycle
- ex_stall  in  1  EX stalled; suppresses all training and statistics
- ex_pc  in  XLEN  PC of the resolved branch
- ex_pred_index  in  BHT_INDEX_BITS  pred_index carried with that branch
- ex_taken  in  1  actual outcome (`branch_taken`)
- ex_target  in  XLEN  actual target (`branch_target_actual`)
- ex_miss  in  1  `branch_prediction_miss`
- stat_branches  out  32  resolved-branch count
- stat_misses  out  32  misprediction count

Behaviour:
- Clock/reset: one clock `clk`; reset `reset_n` is synchronous, active-low. Every state element updates only on the rising edge of `clk`.
- Reset, with `reset_n` = 0 at the edge:
  - all BHT counters := 2'b01 (weakly not-taken);
  - all BTB valid bits := 0;
  - stat_branches := 0, stat_misses := 0.
  - Reset wins over any concurrent update.
  - A branch in flight when reset asserts is discarded.
- Lookup (combinational, zero latency):
  - pred_index = if_pc[BHT_INDEX_BITS+1:2].
  - btb_idx = if_pc[BTB_INDEX_BITS+1:2]; tag = if_pc[XLEN-1:BTB_INDEX_BITS+2].
  - hit = valid[btb_idx] && tag match.
  - pred_taken = hit && counter[pred_index][1].
  - pred_target = pred_taken ? btb_target[btb_idx] : if_pc + 4 (mod 2^XLEN, wraps).
  - Prediction is 0 (not-taken) on BTB miss, even if the counter says taken.
- Training, at the edge when ex_branch && !ex_stall && reset_n:
  - counter[ex_pred_index]: increment on ex_taken, saturating at 2'b11; decrement on !ex_taken, saturating at 2'b00.
  - If ex_taken: BTB[ex_pc index] := {valid=1, tag of ex_pc, ex_target}. Unconditional overwrite; replaces an aliasing entry.
  - Not-taken branches never allocate or invalidate a BTB entry.
  - stat_branches += 1; stat_misses += ex_miss. Both saturate at 32'hFFFF_FFFF.
- Same-cycle lookup and training of the same entry: lookup returns the pre-update value. No write-through bypass; the new value is visible the next cycle.
- ex_branch = 0 or ex_stall = 1: no state changes. ex_* inputs are don't-care.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - adds a BHT_INDEX_BITS global history register (GHR), reset to 0;
  - pred_index = if_pc[BHT_INDEX_BITS+1:2] ^ GHR;
  - on each training event GHR := {GHR[BHT_INDEX_BITS-2:0], ex_taken} (non-speculative, same edge as the counter update);
  - training always uses ex_pred_index, never a recomputed index.
- Undefined: no GHR; behaviour exactly as above.
- BTB indexing is unchanged in both cases.

Decomposition:
- Shared header `branch_predictor.vh`:
  - counter encodings: STRONG_NT = 2'b00, WEAK_NT = 2'b01, WEAK_T = 2'b10, STRONG_T = 2'b11;
  - BHT reset value.
- Sub-module `sat_counter2`: pure combinational next-state of a 2-bit saturating counter from (current, taken). Instantiated on the update path only.

Test Plan:
- Reset with if_pc=0x100 → pred_taken=0, pred_target=0x104, stats=0.
- Train ex_pc=0x100, taken, target 0x80, once → counter 2'b10 and BTB hit → next cycle pred_taken=1, pred_target=0x80; stat_branches=1.
- Two more taken trainings, then three not-taken trainings at 0x100 → counter saturates at 2'b11, then falls to 2'b00 → pred_taken=0, pred_target=0x104; BTB entry remains valid.
- Alias test: taken branch at 0x100, then taken at 0x140 (same BTB index, different tag) → lookup of 0x100 misses (pred_taken=0); 0x140 predicts its own target.
- ex_stall=1 with ex_branch=1, ex_miss=1 → no counter, BTB or statistics change. Then reset_n=0 in the same cycle as a training event → all tables and stats at reset values.
- With BRANCH_PREDICTOR_GSHARE_EN: after one taken branch GHR=1 → lookup of 0x100 gives pred_index = 0x00 ^ 0x01 = 0x01; training a carried ex_pred_index=0x01 updates entry 1 only.
